// File: rtl/sw_ctrl_pkg.sv
// ============================================================================
// Module  : sw_ctrl_pkg
// Brief   : Shared state encoding and default sizing for the Smith-Waterman
//           run sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sw_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SET      = 3'd1,
        SET_WAIT = 3'd2,
        READY    = 3'd3,
        START    = 3'd4,
        RUN      = 3'd5,
        DONE     = 3'd6,
        ERR      = 3'd7
    } state_t;

    localparam int PARAM_W     = 4;
    localparam int DEF_SCORE_W = 18;
    localparam int DEF_CNT_W   = 32;
    // 10 s at 30 MHz
    localparam int DEF_TIMEOUT = 300_000_000;

endpackage

`default_nettype wire

// File: rtl/edge_pulse.sv
// ============================================================================
// Module  : edge_pulse
// Brief   : Rising-edge detector; one-cycle pulse when a debounced level rises.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_pulse (
    input  logic clk,
    input  logic rst_n,
    input  logic i_level,
    output logic o_pulse
);

    logic level_q;
    logic level_d;

    always_comb begin
        level_d = i_level;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_d;
        end
    end

    assign o_pulse = i_level & ~level_q;

endmodule

`default_nettype wire

// File: rtl/sw_run_controller.sv
// ============================================================================
// Module  : sw_run_controller
// Brief   : Sequences set/start presses into core pulses, freezes scoring
//           parameters per run, captures the score and times each run.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sw_run_controller
    import sw_ctrl_pkg::*;
#(
    parameter int SCORE_W = DEF_SCORE_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_set_req,
    input  logic               i_start_req,
    input  logic [PARAM_W-1:0] i_match,
    input  logic [PARAM_W-1:0] i_mismatch,
    input  logic [PARAM_W-1:0] i_minusAlpha,
    input  logic [PARAM_W-1:0] i_minusBeta,
    output logic               o_set_t,
    output logic               o_start_cal,
    output logic [PARAM_W-1:0] o_match,
    output logic [PARAM_W-1:0] o_mismatch,
    output logic [PARAM_W-1:0] o_minusAlpha,
    output logic [PARAM_W-1:0] o_minusBeta,
    input  logic               i_busy,
    input  logic               i_valid,
    input  logic [SCORE_W-1:0] i_result,
    output logic [SCORE_W-1:0] o_score,
    output logic [CNT_W-1:0]   o_cycles,
    output logic               o_is_set,
    output logic               o_done,
    output logic               o_timeout,
    output logic [2:0]         o_state
);

    // Count value at which the current RUN cycle is the TIMEOUT-th one
    localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(TIMEOUT - 1);

    logic w_set_pulse;
    logic w_start_pulse;

    state_t             state_q,    state_d;
    logic [PARAM_W-1:0] match_q,    match_d;
    logic [PARAM_W-1:0] mismatch_q, mismatch_d;
    logic [PARAM_W-1:0] alpha_q,    alpha_d;
    logic [PARAM_W-1:0] beta_q,     beta_d;
    logic [SCORE_W-1:0] score_q,    score_d;
    logic [CNT_W-1:0]   cycles_q,   cycles_d;
    logic               is_set_q,   is_set_d;

    edge_pulse u_set_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_level (i_set_req),
        .o_pulse (w_set_pulse)
    );

    edge_pulse u_start_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_level (i_start_req),
        .o_pulse (w_start_pulse)
    );

    always_comb begin
        state_d    = state_q;
        match_d    = match_q;
        mismatch_d = mismatch_q;
        alpha_d    = alpha_q;
        beta_d     = beta_q;
        score_d    = score_q;
        cycles_d   = cycles_q;
        is_set_d   = is_set_q;

        case (state_q)
            IDLE: begin
                if (w_set_pulse) state_d = SET;
            end
            SET: begin
                state_d = SET_WAIT;
            end
            SET_WAIT: begin
                if (!i_busy) begin
                    state_d  = READY;
                    is_set_d = 1'b1;
                end
            end
            READY, DONE: begin
                // Set outranks start when both rise together
                if (w_set_pulse)        state_d = SET;
                else if (w_start_pulse) state_d = START;
            end
            START: begin
                cycles_d = '0;
                state_d  = RUN;
            end
            RUN: begin
                if (cycles_q != {CNT_W{1'b1}}) cycles_d = cycles_q + CNT_W'(1);
                if (i_valid) begin
                    score_d = i_result;
                    state_d = DONE;
                end else if (cycles_q >= c_timeout_last) begin
                    state_d = ERR;
                end
            end
            ERR: begin
                if (w_set_pulse) state_d = SET;
            end
            default: state_d = IDLE;
        endcase

        // SET is only ever entered from another state, so this is the entry edge
        if (state_d == SET) begin
            match_d    = i_match;
            mismatch_d = i_mismatch;
            alpha_d    = i_minusAlpha;
            beta_d     = i_minusBeta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            match_q    <= '0;
            mismatch_q <= '0;
            alpha_q    <= '0;
            beta_q     <= '0;
            score_q    <= '0;
            cycles_q   <= '0;
            is_set_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            match_q    <= match_d;
            mismatch_q <= mismatch_d;
            alpha_q    <= alpha_d;
            beta_q     <= beta_d;
            score_q    <= score_d;
            cycles_q   <= cycles_d;
            is_set_q   <= is_set_d;
        end
    end

    assign o_set_t      = (state_q == SET);
    assign o_start_cal  = (state_q == START);
    assign o_done       = (state_q == DONE);
    assign o_timeout    = (state_q == ERR);
    assign o_state      = state_q;
    assign o_match      = match_q;
    assign o_mismatch   = mismatch_q;
    assign o_minusAlpha = alpha_q;
    assign o_minusBeta  = beta_q;
    assign o_score      = score_q;
    assign o_cycles     = cycles_q;
    assign o_is_set     = is_set_q;

endmodule

`default_nettype wire

// File: tb/tb_sw_run_controller.sv
// ============================================================================
// Module  : tb_sw_run_controller
// Brief   : Self-checking bench for sw_run_controller against a cycle model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sw_run_controller;

    localparam int SCORE_W = 18;
    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 20;

    localparam int P_IDLE = 0, P_SET = 1, P_WAIT = 2, P_READY = 3;
    localparam int P_START = 4, P_RUN = 5, P_DONE = 6, P_ERR = 7;

    logic               clk;
    logic               rst_n;
    logic               i_set_req, i_start_req;
    logic [3:0]         i_match, i_mismatch, i_minusAlpha, i_minusBeta;
    logic               o_set_t, o_start_cal;
    logic [3:0]         o_match, o_mismatch, o_minusAlpha, o_minusBeta;
    logic               i_busy, i_valid;
    logic [SCORE_W-1:0] i_result;
    logic [SCORE_W-1:0] o_score;
    logic [CNT_W-1:0]   o_cycles;
    logic               o_is_set, o_done, o_timeout;
    logic [2:0]         o_state;

    sw_run_controller #(
        .SCORE_W (SCORE_W),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_set_req    (i_set_req),
        .i_start_req  (i_start_req),
        .i_match      (i_match),
        .i_mismatch   (i_mismatch),
        .i_minusAlpha (i_minusAlpha),
        .i_minusBeta  (i_minusBeta),
        .o_set_t      (o_set_t),
        .o_start_cal  (o_start_cal),
        .o_match      (o_match),
        .o_mismatch   (o_mismatch),
        .o_minusAlpha (o_minusAlpha),
        .o_minusBeta  (o_minusBeta),
        .i_busy       (i_busy),
        .i_valid      (i_valid),
        .i_result     (i_result),
        .o_score      (o_score),
        .o_cycles     (o_cycles),
        .o_is_set     (o_is_set),
        .o_done       (o_done),
        .o_timeout    (o_timeout),
        .o_state      (o_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // Reference model: phase number, request history, frozen values
    int               m_phase;
    logic             m_prev_set, m_prev_start;
    logic [3:0]       m_par [4];
    logic [SCORE_W-1:0] m_score;
    logic [CNT_W-1:0] m_cycles;
    logic             m_loaded;

    task automatic model_reset();
        m_phase      = P_IDLE;
        m_prev_set   = 1'b0;
        m_prev_start = 1'b0;
        for (int k = 0; k < 4; k++) m_par[k] = 4'd0;
        m_score  = '0;
        m_cycles = '0;
        m_loaded = 1'b0;
    endtask

    task automatic go_set();
        m_phase  = P_SET;
        m_par[0] = i_match;
        m_par[1] = i_mismatch;
        m_par[2] = i_minusAlpha;
        m_par[3] = i_minusBeta;
    endtask

    task automatic model_step();
        bit sp, st;
        sp = i_set_req && !m_prev_set;
        st = i_start_req && !m_prev_start;
        m_prev_set   = i_set_req;
        m_prev_start = i_start_req;
        case (m_phase)
            P_IDLE:  if (sp) go_set();
            P_SET:   m_phase = P_WAIT;
            P_WAIT:  if (!i_busy) begin m_phase = P_READY; m_loaded = 1'b1; end
            P_READY, P_DONE: begin
                if (sp) go_set();
                else if (st) m_phase = P_START;
            end
            P_START: begin m_cycles = '0; m_phase = P_RUN; end
            P_RUN: begin
                if (m_cycles != {CNT_W{1'b1}}) m_cycles = m_cycles + 1;
                if (i_valid) begin
                    m_score = i_result;
                    m_phase = P_DONE;
                end else if (m_cycles >= TIMEOUT) begin
                    m_phase = P_ERR;
                end
            end
            P_ERR:   if (sp) go_set();
            default: m_phase = P_IDLE;
        endcase
    endtask

    task automatic check_all();
        chk("state",    o_state,      m_phase);
        chk("set_t",    o_set_t,      m_phase == P_SET);
        chk("start",    o_start_cal,  m_phase == P_START);
        chk("done",     o_done,       m_phase == P_DONE);
        chk("timeout",  o_timeout,    m_phase == P_ERR);
        chk("match",    o_match,      m_par[0]);
        chk("mismatch", o_mismatch,   m_par[1]);
        chk("alpha",    o_minusAlpha, m_par[2]);
        chk("beta",     o_minusBeta,  m_par[3]);
        chk("score",    o_score,      m_score);
        chk("cycles",   o_cycles,     m_cycles);
        chk("is_set",   o_is_set,     m_loaded);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (!rst_n) model_reset();
        else model_step();
        check_all();
    endtask

    int cnt;

    initial begin
        rst_n = 1'b0;
        {i_set_req, i_start_req, i_busy, i_valid} = 4'b0;
        {i_match, i_mismatch, i_minusAlpha, i_minusBeta} = 16'h0;
        i_result = '0;
        model_reset();

        // 1: reset values, start in IDLE ignored
        #2;
        check_all();
        cyc(); cyc();
        chk("t1_rst_state", o_state, 0);
        rst_n = 1'b1;
        i_start_req = 1'b1;
        cyc();
        i_start_req = 1'b0;
        cyc();
        chk("t1_idle_start", o_start_cal, 0);
        chk("t1_idle_state", o_state, P_IDLE);

        // 2: set with 2/1/3/1, core idle
        {i_match, i_mismatch, i_minusAlpha, i_minusBeta} = {4'd2, 4'd1, 4'd3, 4'd1};
        i_set_req = 1'b1;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            cnt += int'(o_set_t);
            i_set_req = 1'b0;
        end
        chk("t2_set_pulses", cnt, 1);
        chk("t2_match", o_match, 2);
        chk("t2_beta", o_minusBeta, 1);
        chk("t2_ready", o_state, P_READY);
        chk("t2_is_set", o_is_set, 1);

        // 3: run, valid on 5th RUN cycle with score 37; switches moved mid-run
        i_start_req = 1'b1;
        cyc();
        i_start_req = 1'b0;
        cyc();
        i_match = 4'd15;
        for (int k = 0; k < 4; k++) cyc();
        i_valid = 1'b1;
        i_result = 18'd37;
        cyc();
        i_valid = 1'b0;
        chk("t3_score", o_score, 37);
        chk("t3_cycles", o_cycles, 5);
        chk("t3_done", o_done, 1);
        chk("t5_match_frozen", o_match, 2);

        // 4: rerun without valid -> timeout after TIMEOUT RUN cycles
        i_start_req = 1'b1;
        cyc();
        i_start_req = 1'b0;
        for (int k = 0; k < 40 && !o_timeout; k++) cyc();
        chk("t4_timeout", o_timeout, 1);
        chk("t4_cycles", o_cycles, TIMEOUT);
        i_start_req = 1'b1;
        cyc();
        i_start_req = 1'b0;
        cyc();
        chk("t4_err_start", o_state, P_ERR);
        i_set_req = 1'b1;
        i_busy = 1'b1;
        cyc();
        i_set_req = 1'b0;
        chk("t4_set_state", o_state, P_SET);
        chk("t4_timeout_clr", o_timeout, 0);
        for (int k = 0; k < 3; k++) cyc();
        chk("t4_busy_wait", o_state, P_WAIT);
        i_busy = 1'b0;
        cyc();

        // 5: run to DONE, then set+start together
        i_start_req = 1'b1;
        cyc();
        i_start_req = 1'b0;
        cyc(); cyc();
        i_valid = 1'b1;
        i_result = 18'h2ABCD;
        cyc();
        i_valid = 1'b0;
        i_set_req = 1'b1;
        i_start_req = 1'b1;
        cyc();
        chk("t5_both_set", o_set_t, 1);
        chk("t5_both_start", o_start_cal, 0);
        i_set_req = 1'b0;
        i_start_req = 1'b0;
        cyc(); cyc();

        // 6: held start gives one pulse; then reset mid-RUN
        i_start_req = 1'b1;
        cnt = 0;
        for (int k = 0; k < 50; k++) begin
            cyc();
            cnt += int'(o_start_cal);
        end
        i_start_req = 1'b0;
        chk("t6_single_start", cnt, 1);
        i_set_req = 1'b1;
        cyc();
        i_set_req = 1'b0;
        cyc(); cyc();
        i_start_req = 1'b1;
        cyc();
        i_start_req = 1'b0;
        for (int k = 0; k < 4; k++) cyc();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("t6_rst_state", o_state, P_IDLE);
        chk("t6_rst_cycles", o_cycles, 0);
        chk("t6_rst_is_set", o_is_set, 0);
        cyc();
        rst_n = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 19) == 0) i_set_req = ~i_set_req;
            if ($urandom_range(0, 7) == 0) i_start_req = ~i_start_req;
            i_busy   = ($urandom_range(0, 2) == 0);
            i_valid  = ($urandom_range(0, 24) == 0);
            i_result = SCORE_W'($urandom);
            {i_match, i_mismatch, i_minusAlpha, i_minusBeta} = 16'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                check_all();
                cyc();
                rst_n = 1'b1;
            end else begin
                cyc();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
